// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and helpers for the sequential magnitude comparator.
//   state_e          FSM state encoding (idle / run / done)
//   CMP_GT/EQ/LT     encoding of a single comparison outcome
//   clog2()          ceiling log2, used to size the chunk index
package cmp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [1:0] CMP_GT = 2'd0;
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational unsigned comparator for one CHUNK-bit slice.
// Ports:
//   i_a, i_b   slices of operand A and B
//   o_gt       i_a > i_b
//   o_eq       i_a == i_b
//   o_lt       i_a < i_b
module cmp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  always_comb begin
    o_gt = (i_a > i_b);
    o_eq = (i_a == i_b);
    o_lt = (i_a < i_b);
  end

endmodule

// File: rtl/cmp_seq.sv
// cmp_seq: multi-cycle magnitude comparator, signed or unsigned, scanning MSB-first
// CHUNK bits per cycle and stopping at the first unequal chunk.
// Optional feature macro: CMP_MINMAX_EN adds registered max/min operand outputs.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   request handshake; a, b, sign are sampled on accept
//   out_valid, out_ready result handshake; gt/eq/lt held until accepted
//   max, min             larger / smaller operand (CMP_MINMAX_EN only)
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] min
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_e           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sign;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
`endif

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_ch_gt;
  logic             w_ch_eq;
  logic             w_ch_lt;
  logic             w_flip;
  logic [1:0]       w_res;

  always_comb begin
    w_ca = r_a[r_idx*CHUNK +: CHUNK];
    w_cb = r_b[r_idx*CHUNK +: CHUNK];
  end

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a  (w_ca),
    .i_b  (w_cb),
    .o_gt (w_ch_gt),
    .o_eq (w_ch_eq),
    .o_lt (w_ch_lt)
  );

  // With differing sign bits the top chunk always differs, so the unsigned verdict
  // from that chunk is simply inverted for a two's-complement compare.
  assign w_flip = r_sign & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);

  always_comb begin
    w_res = CMP_EQ;
    unique case ({w_ch_gt, w_ch_eq, w_ch_lt})
      3'b100:  w_res = w_flip ? CMP_LT : CMP_GT;
      3'b001:  w_res = w_flip ? CMP_GT : CMP_LT;
      3'b010:  w_res = CMP_EQ;
      default: w_res = CMP_EQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
`ifdef CMP_MINMAX_EN
      r_max       <= '0;
      r_min       <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_sign     <= sign;
            r_idx      <= IDX_TOP;
            r_in_ready <= 1'b0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          if ((w_res != CMP_EQ) || (r_idx == '0)) begin
            r_gt        <= (w_res == CMP_GT);
            r_eq        <= (w_res == CMP_EQ);
            r_lt        <= (w_res == CMP_LT);
            r_out_valid <= 1'b1;
            r_state     <= StDone;
`ifdef CMP_MINMAX_EN
            // Equal operands fall into the else arm, giving A on both outputs.
            if (w_res == CMP_GT) begin
              r_max <= r_a;
              r_min <= r_b;
            end else begin
              r_max <= r_b;
              r_min <= r_a;
            end
`endif
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign gt        = r_gt;
  assign eq        = r_eq;
  assign lt        = r_lt;
`ifdef CMP_MINMAX_EN
  assign max       = r_max;
  assign min       = r_min;
`endif

endmodule
